// File: rtl/custom_ahb_busmatrix_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : custom_ahb_busmatrix_output_arbiter
// Description : Round-robin arbiter for one busmatrix output (slave) port.
//               Registers a one-hot address-phase grant and the matching
//               one-hot data-phase owner. It holds the grant across SEQ/BUSY
//               beats and across locked sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module custom_ahb_busmatrix_output_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int MID_W       = 2
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] hmastlock,
  input  logic [1:0]             htrans_sel,
  input  logic                   HREADYM,
  output logic [NUM_MASTERS-1:0] addr_sel,
  output logic [NUM_MASTERS-1:0] data_sel,
  output logic                   no_port,
  output logic [MID_W-1:0]       master_id
);

  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  logic [NUM_MASTERS-1:0] addr_sel_r;
  logic [NUM_MASTERS-1:0] data_sel_r;
  logic [MID_W-1:0]       ptr_r;

  logic [MID_W-1:0]       grant_idx;
  logic                   granted;
  logic                   hold;
  logic                   win_found;
  logic [MID_W-1:0]       win_idx;
  int                     search_idx;

  assign granted   = |addr_sel_r;
  assign addr_sel  = addr_sel_r;
  assign data_sel  = data_sel_r;
  assign no_port   = ~granted;
  assign master_id = grant_idx;

  // Binary encode the one-hot address grant; zero when nobody owns the port.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (addr_sel_r[i]) grant_idx = MID_W'(i);
    end
  end

  // The current owner keeps the port while locked, or mid-burst while it
  // still requests. A locked owner keeps it even through IDLE with no req.
  always_comb begin
    hold = 1'b0;
    if (granted) begin
      if (hmastlock[grant_idx]) begin
        hold = 1'b1;
      end else if (((htrans_sel == HTRANS_SEQ) || (htrans_sel == HTRANS_BUSY)) &&
                   req[grant_idx]) begin
        hold = 1'b1;
      end
    end
  end

  // Round-robin search beginning one past the last winner, wrapping to 0.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    search_idx = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      search_idx = (int'(ptr_r) + k) % NUM_MASTERS;
      if (!win_found && req[search_idx]) begin
        win_found = 1'b1;
        win_idx   = MID_W'(search_idx);
      end
    end
  end

  // Grant, data-phase owner and pointer only move on a completed transfer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_sel_r <= '0;
      data_sel_r <= '0;
      ptr_r      <= MID_W'(NUM_MASTERS - 1);
    end else if (HREADYM) begin
      data_sel_r <= addr_sel_r;
      if (hold) begin
        addr_sel_r <= addr_sel_r;
      end else if (win_found) begin
        addr_sel_r <= NUM_MASTERS'(1) << win_idx;
        ptr_r      <= win_idx;
      end else begin
        addr_sel_r <= '0;
      end
    end
  end

endmodule
`default_nettype wire
